// File: rtl/sensor_scheduler.sv
// Round-robin poller for four temperature sensors on a shared req/ack bus.
// Produces one floor-averaged signed reading per period and flags channel timeouts.
module sensor_scheduler #(
    parameter logic [15:0] PERIOD  = 16'd1000,
    parameter logic [7:0]  TIMEOUT = 8'd20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sens_ack,
    input  logic signed [7:0] sens_data,
    output logic [3:0]        sens_req,
    output logic signed [7:0] temp_out,
    output logic              temp_valid,
    output logic [3:0]        fault,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, AVG} state_t;

    state_t            state, state_nx;
    logic [15:0]       pcnt;
    logic              tick;
    logic [1:0]        ch;
    logic [7:0]        timer;
    logic signed [7:0] slot [4];
    logic [2:0]        fails;
    logic              acked;
    logic              timed_out;
    logic signed [9:0] sum;
    logic signed [9:0] avg;

    assign tick      = (pcnt == PERIOD - 16'd1);
    assign acked     = (state == REQ) && sens_ack;
    // An ack on the timeout edge takes priority, so timeout requires no ack.
    assign timed_out = (state == REQ) && !sens_ack && (timer == TIMEOUT - 8'd1);
    assign sum       = 10'(slot[0]) + 10'(slot[1]) + 10'(slot[2]) + 10'(slot[3]);
    assign avg       = sum >>> 2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sens_req = '0;
        busy     = (state != IDLE);
        case (state)
            IDLE: if (tick) state_nx = REQ;
            REQ: begin
                sens_req = 4'b0001 << ch;
                if (acked || timed_out) state_nx = GAP;
            end
            GAP:     state_nx = (ch == 2'd3) ? AVG : REQ;
            AVG:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt       <= '0;
            ch         <= '0;
            timer      <= '0;
            fails      <= '0;
            fault      <= '0;
            temp_out   <= '0;
            temp_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) slot[i] <= '0;
        end else begin
            pcnt       <= tick ? '0 : pcnt + 16'd1;
            temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        timer <= '0;
                        fails <= '0;
                    end
                end
                REQ: begin
                    if (acked) begin
                        slot[ch]  <= sens_data;
                        fault[ch] <= 1'b0;
                    end else if (timed_out) begin
                        slot[ch]  <= temp_out;
                        fault[ch] <= 1'b1;
                        fails     <= fails + 3'd1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                GAP: begin
                    timer <= '0;
                    if (ch != 2'd3) ch <= ch + 2'd1;
                end
                AVG: begin
                    if (fails < 3'd4) begin
                        temp_out   <= avg[7:0];
                        temp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler: a sensor responder model drives the bus and
// a scoreboard monitor checks every temp_valid pulse against queued expected averages.
module tb_sensor_scheduler;

    localparam logic [15:0] P  = 16'd16;
    localparam logic [7:0]  TO = 8'd5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sens_ack = 1'b0;
    logic signed [7:0] sens_data = '0;
    logic [3:0]        sens_req;
    logic signed [7:0] temp_out;
    logic              temp_valid;
    logic [3:0]        fault;
    logic              busy;

    int                checks = 0;
    int                failures = 0;
    logic signed [7:0] expq [$];

    // Responder configuration: ack delay in REQ cycles (255 = never) and data per channel.
    int                dly [4];
    logic signed [7:0] dat [4];
    bit                spur = 1'b0;

    sensor_scheduler #(.PERIOD(P), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .sens_ack(sens_ack), .sens_data(sens_data),
        .sens_req(sens_req), .temp_out(temp_out), .temp_valid(temp_valid),
        .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        int wc;
        int c;
        wc = 0;
        forever begin
            @(negedge clk);
            if (sens_req != 4'b0000) begin
                c = sens_req[0] ? 0 : sens_req[1] ? 1 : sens_req[2] ? 2 : 3;
                if (wc == dly[c]) begin
                    sens_ack  = 1'b1;
                    sens_data = dat[c];
                end else begin
                    sens_ack  = 1'b0;
                end
                wc++;
            end else begin
                wc        = 0;
                sens_ack  = spur;
                sens_data = spur ? 8'sd99 : 8'sd0;
            end
        end
    end

    initial begin
        logic signed [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (temp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=%0d expected=no_pulse", temp_out);
                end else begin
                    e = expq.pop_front();
                    chk("temp_out", int'(temp_out), int'(e));
                end
            end
        end
    end

    task automatic set_all(input int d, input logic signed [7:0] v);
        for (int i = 0; i < 4; i++) begin
            dly[i] = d;
            dat[i] = v;
        end
    endtask

    task automatic wait_round(output int req2);
        int n;
        req2 = 0;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("round_start", int'(busy), 1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (sens_req == 4'b0100) req2++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("round_end", int'(busy), 0);
    endtask

    initial begin
        int r2;
        int n;
        logic [3:0] rq [31];
        logic       tv [31];
        logic       bz [31];

        set_all(0, 8'sd0);
        dat[0] = 8'sd20; dat[1] = 8'sd21; dat[2] = 8'sd22; dat[3] = 8'sd23;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sens_req", int'(sens_req), 0);
        chk("rst_temp_out", int'(temp_out), 0);
        chk("rst_temp_valid", int'(temp_valid), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_busy", int'(busy), 0);

        // Round 1: zero-wait acks 20..23, cycle-accurate timing from reset release.
        expq.push_back(8'sd21);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 31; c++) begin
            rq[c] = sens_req;
            tv[c] = temp_valid;
            bz[c] = busy;
            @(posedge clk);
            #1;
        end
        chk("busy_c15", int'(bz[15]), 0);
        chk("req_c16", int'(rq[16]), 1);
        chk("req_c17", int'(rq[17]), 0);
        chk("req_c18", int'(rq[18]), 2);
        chk("req_c20", int'(rq[20]), 4);
        chk("req_c22", int'(rq[22]), 8);
        chk("req_c23", int'(rq[23]), 0);
        chk("busy_c24", int'(bz[24]), 1);
        chk("valid_c24", int'(tv[24]), 0);
        chk("valid_c25", int'(tv[25]), 1);
        chk("valid_c26", int'(tv[26]), 0);
        chk("busy_c25", int'(bz[25]), 0);

        // Round 2: negative floor rounding.
        set_all(0, 8'sd0);
        dat[0] = -8'sd1; dat[1] = -8'sd2;
        expq.push_back(-8'sd1);
        wait_round(r2);

        // Round 3a: set up temp_out = 30.
        set_all(0, 8'sd30);
        expq.push_back(8'sd30);
        wait_round(r2);

        // Round 3b: channel 2 silent, replaced by previous average 30.
        dat[1] = 8'sd34; dat[3] = 8'sd38; dly[2] = 255;
        expq.push_back(8'sd33);
        wait_round(r2);
        chk("ch2_req_cycles", r2, 5);
        chk("fault_ch2", int'(fault), 4);

        // Round 4: channel 2 recovers.
        set_all(0, 8'sd33);
        expq.push_back(8'sd33);
        wait_round(r2);
        chk("fault_recover", int'(fault), 0);

        // Round 5: all silent, no pulse expected.
        set_all(255, 8'sd0);
        wait_round(r2);
        chk("fault_all", int'(fault), 15);
        chk("temp_hold", int'(temp_out), 33);
        chk("busy_after_avg", int'(busy), 0);

        // Round 6: ch1 acks on the timeout edge; spurious acks while req is low.
        set_all(0, 8'sd40);
        dly[1] = 4; dat[1] = 8'sd44;
        spur = 1'b1;
        expq.push_back(8'sd41);
        wait_round(r2);
        chk("fault_ack_wins", int'(fault), 0);
        spur = 1'b0;

        // Round 7: reset during REQ1 with slow acks.
        set_all(3, 8'sd50);
        n = 0;
        while (sens_req != 4'b0010 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_req1", int'(sens_req), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_sens_req", int'(sens_req), 0);
        chk("midrst_temp_out", int'(temp_out), 0);
        chk("midrst_temp_valid", int'(temp_valid), 0);
        chk("midrst_fault", int'(fault), 0);
        chk("midrst_busy", int'(busy), 0);
        set_all(0, 8'sd8);
        expq.push_back(8'sd8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        wait_round(r2);
        chk("fault_post_rst", int'(fault), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/sensor_scheduler.md
# sensor_scheduler

Round-robin poller that sequences four incubator temperature sensors over a shared request/acknowledge bus. It builds one averaged signed 8-bit reading per sampling period and feeds it to the incubator climate controller's `sensor` input. Channel timeouts are flagged as faults, and the last good average stands in for a failed channel.

## Interface
- `PERIOD`, default 16'd1000: cycles between round starts; valid range 2..65535.
- `TIMEOUT`, default 8'd20: maximum cycles `sens_req` is held per channel; valid range 1..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sens_ack` in 1: sensor acknowledge; data valid when high.
- `sens_data` in 8 signed: reading from the addressed sensor.
- `sens_req` out 4: one-hot request; bit i selects sensor i.
- `temp_out` out 8 signed: latest averaged temperature.
- `temp_valid` out 1: one-cycle pulse when `temp_out` updates.
- `fault` out 4: bit i high means channel i timed out on its most recent poll.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, REQ, GAP, AVG.
- Period counter:
  - Free-runs 0..PERIOD-1 in every state and wraps to 0.
  - A tick occurs when the count equals PERIOD-1.
- IDLE:
  - On tick, channel index goes to 0 and the state goes to REQ.
  - A tick that arrives in any state other than IDLE is dropped; no queueing.
- REQ:
  - `sens_req` = one-hot(channel).
  - A timer clears on entry and increments each REQ cycle without an ack.
- Ack sampled high in REQ:
  - Slot[channel] <= `sens_data`.
  - `fault[channel]` <= 0.
  - The round-failure count is unchanged.
  - Next state is GAP.
- No ack when the timer equals TIMEOUT-1:
  - Slot[channel] <= current `temp_out`.
  - `fault[channel]` <= 1.
  - The round-failure count is incremented.
  - Next state is GAP.
- Ack and timeout on the same edge: the ack wins.
- GAP: `sens_req` = 0 for exactly one cycle. If channel == 3, go to AVG; otherwise increment channel and go to REQ.
- AVG:
  - Sum the four slots sign-extended to 10 bits, then arithmetic shift right by 2 (floor division).
  - If the round-failure count is below 4, load `temp_out` and pulse `temp_valid`.
  - If all four channels failed, `temp_out` holds and there is no pulse.
  - In both cases go to IDLE; the failure count clears on round start.
- `sens_ack` is ignored whenever `sens_req` = 0.
- `fault` bits are sticky across rounds until the channel acks again.

## Timing
- Reset values:
  - `sens_req` = 0, `temp_out` = 0, `temp_valid` = 0, `fault` = 0, `busy` = 0.
  - State IDLE, period counter 0, all slots 0.
- Reset mid-round: `sens_req` drops asynchronously; the round is abandoned, with no partial update.
- First tick falls in cycle PERIOD-1 after reset release (counting cycle 0).
- Zero-wait acks (ack high in the first REQ cycle), with the tick in cycle T:
  - REQ0 in T+1; REQ1, REQ2, REQ3 in T+3, T+5, T+7.
  - AVG in T+9.
  - `temp_valid` high and the new `temp_out` visible in T+10.
- Per channel the sensor sees `sens_req` high for 1..TIMEOUT cycles, then low for at least 1 cycle.
- `sens_req` deasserts in the cycle after the ack edge.
- Worst-case round is 4*(TIMEOUT+1)+1 cycles. PERIOD must exceed this or ticks are dropped.
- `temp_valid` is exactly one cycle wide; `temp_out` is stable between pulses.

## Test plan
- Reset, then PERIOD=16 with zero-wait acks returning 20, 21, 22, 23: tick in cycle 15; `sens_req` = 0001/0010/0100/1000 in cycles 16/18/20/22; `temp_valid` in cycle 25; `temp_out` = 21.
- Negative rounding, acks returning -1, -2, 0, 0: `temp_out` = -1 (sum -3, floor).
- Channel 2 never acks, TIMEOUT=5, previous `temp_out` = 30, others return 30, 34, 38:
  - `sens_req` = 0100 for exactly 5 cycles.
  - `fault` = 0100.
  - `temp_out` = (30+34+30+38)>>2 = 33.
  - On the next round channel 2 acks, `fault` returns to 0000.
- All channels silent: `fault` = 1111; no `temp_valid`; `temp_out` unchanged; `busy` low after AVG.
- Ack arrives on the same edge as the timeout: data captured and fault bit stays 0. Ack pulses while `sens_req` = 0 leave state and slots unchanged.
- `reset` asserted during REQ1 with slow acks: `sens_req` = 0 immediately and all outputs at reset values. After release, the next valid pulse comes from a full new round.
